fetch_queue: RTL and testbench

- Instruction fetch front end. Sits directly upstream of the IF/ID segmentation register and replaces the bare pc_register/adder/mux PC path.
- Owns the word-addressed PC and issues requests to the synchronous instruction port of the memory, which returns data one cycle after the request.
- Buffers fetched words with their PCs in a small FIFO so that ID stalls do not lose instructions.
- Flushes the FIFO and in-flight fetch on a taken-jump redirect from EX.

---
 rtl/fetch_queue.sv | 139 +++++++++++++
 tb/tb_fetch_queue.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue.sv
// Instruction fetch front end: owns the PC, issues imem requests, buffers {instr, pc}; empty-to-out latency 2 cycles.
// stall_id holds the head and stops requests once full; redirect flushes everything. FETCH_PERF_EN adds pop/flush counters.
module fetch_queue #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'd0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     fetch_en,
    output logic                     imem_req,
    output logic [31:0]              imem_addr,
    input  logic [31:0]              imem_rdata,
    input  logic                     redirect,
    input  logic [31:0]              redirect_pc,
    input  logic                     stall_id,
    output logic                     out_valid,
    output logic [31:0]              out_instr,
    output logic [31:0]              out_pc,
    output logic [$clog2(DEPTH):0]   occupancy,
    output logic [31:0]              perf_fetched,
    output logic [31:0]              perf_flushed
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 2;

    logic [AW-1:0] head_q, head_d;
    logic [AW-1:0] tail_q, tail_d;
    logic [AW:0]   count_q, count_d;
    logic          inflight_q, inflight_d;
    logic [31:0]   pc_q, pc_d;
    logic [31:0]   req_pc_q, req_pc_d;
    logic [31:0]   instr_q [DEPTH];
    logic [31:0]   pcs_q   [DEPTH];

    logic          pop;
    logic          push;
    logic [CW-1:0] demand;

    assign out_valid = (count_q != '0) && !redirect;
    assign out_instr = out_valid ? instr_q[head_q] : 32'd0;
    assign out_pc    = out_valid ? pcs_q[head_q]   : 32'd0;
    assign pop       = out_valid && !stall_id;
    assign push      = inflight_q && !redirect;
    assign occupancy = count_q;
    assign imem_addr = pc_q;

    // Slots already promised (held + in flight), less the one leaving this cycle.
    assign demand   = CW'(count_q) + CW'(inflight_q) - CW'(pop);
    assign imem_req = fetch_en && !redirect && !rst && (demand < CW'(DEPTH));

    always_comb begin
        head_d     = head_q;
        tail_d     = tail_q;
        count_d    = count_q;
        pc_d       = pc_q;
        req_pc_d   = req_pc_q;
        inflight_d = imem_req;

        if (imem_req) begin
            req_pc_d = pc_q;
            pc_d     = pc_q + 32'd1;
        end
        if (pop) begin
            head_d = head_q + AW'(1);
        end
        if (push) begin
            tail_d = tail_q + AW'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase

        if (redirect) begin
            head_d     = '0;
            tail_d     = '0;
            count_d    = '0;
            inflight_d = 1'b0;
            pc_d       = redirect_pc;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            inflight_q <= 1'b0;
            pc_q       <= RESET_PC;
            req_pc_q   <= 32'd0;
        end else begin
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            inflight_q <= inflight_d;
            pc_q       <= pc_d;
            req_pc_q   <= req_pc_d;
        end
    end

    // Payload storage needs no reset; count_q alone defines which slots are live.
    always_ff @(posedge clk) begin
        if (push && !rst) begin
            instr_q[tail_q] <= imem_rdata;
            pcs_q[tail_q]   <= req_pc_q;
        end
    end

    ovf_chk: assert property (@(posedge clk) disable iff (rst)
        !(push && !pop && (count_q == (AW+1)'(DEPTH))));

`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetched_q;
    logic [31:0] perf_flushed_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_fetched_q <= 32'd0;
            perf_flushed_q <= 32'd0;
        end else begin
            if (pop) begin
                perf_fetched_q <= perf_fetched_q + 32'd1;
            end
            if (redirect) begin
                perf_flushed_q <= perf_flushed_q + 32'(count_q) + 32'(inflight_q);
            end
        end
    end

    assign perf_fetched = perf_fetched_q;
    assign perf_flushed = perf_flushed_q;
`else
    assign perf_fetched = 32'd0;
    assign perf_flushed = 32'd0;
`endif

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue; imem model returns addr+0x100 one cycle after each request.
module tb_fetch_queue;

    logic        clk = 1'b0;
    logic        rst;
    logic        fetch_en;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        stall_id;
    logic        out_valid;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic [2:0]  occupancy;
    logic [31:0] perf_fetched;
    logic [31:0] perf_flushed;

    int n_chk  = 0;
    int n_pass = 0;

    fetch_queue #(.DEPTH(4), .RESET_PC(32'd0)) dut (
        .clk(clk), .rst(rst), .fetch_en(fetch_en),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
        .redirect(redirect), .redirect_pc(redirect_pc), .stall_id(stall_id),
        .out_valid(out_valid), .out_instr(out_instr), .out_pc(out_pc),
        .occupancy(occupancy), .perf_fetched(perf_fetched), .perf_flushed(perf_flushed)
    );

    always #5 clk = ~clk;

    always @(posedge clk)
        imem_rdata <= imem_req ? imem_addr + 32'h100 : 32'hDEAD_BEEF;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout want finish");
        $fatal(1);
    end

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; fetch_en = 1'b0; stall_id = 1'b0;
        redirect = 1'b0; redirect_pc = 32'd0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; fetch_en = 1'b1; stall_id = 1'b0;
        redirect = 1'b0; redirect_pc = 32'd0;
        repeat (3) @(negedge clk);
        #1;
        n_chk++; if (imem_req !== 1'b0) $display("FAIL rst_req got %b want 0", imem_req); else n_pass++;
        n_chk++; if (out_valid !== 1'b0) $display("FAIL rst_valid got %b want 0", out_valid); else n_pass++;
        n_chk++; if (occupancy !== 3'd0) $display("FAIL rst_occ got %0d want 0", occupancy); else n_pass++;
        n_chk++; if (imem_addr !== 32'd0) $display("FAIL rst_addr got %h want 0", imem_addr); else n_pass++;
        n_chk++; if (out_instr !== 32'd0) $display("FAIL rst_instr got %h want 0", out_instr); else n_pass++;
        n_chk++; if (out_pc !== 32'd0) $display("FAIL rst_pc got %h want 0", out_pc); else n_pass++;
        n_chk++; if (perf_fetched !== 32'd0) $display("FAIL rst_perf_fetched got %0d want 0", perf_fetched); else n_pass++;
        n_chk++; if (perf_flushed !== 32'd0) $display("FAIL rst_perf_flushed got %0d want 0", perf_flushed); else n_pass++;
        rst = 1'b0; fetch_en = 1'b0;
        #1;
        n_chk++; if (imem_req !== 1'b0) $display("FAIL fetch_en_low_req got %b want 0", imem_req); else n_pass++;
    endtask

    task automatic test_stream();
        do_reset();
        fetch_en = 1'b1;
        for (int k = 0; k < 8; k++) begin
            if (k > 0) @(negedge clk);
            #1;
            n_chk++; if (imem_addr !== 32'(k)) $display("FAIL stream_addr k=%0d got %h want %h", k, imem_addr, k); else n_pass++;
            n_chk++; if (imem_req !== 1'b1) $display("FAIL stream_req k=%0d got %b want 1", k, imem_req); else n_pass++;
            n_chk++; if (out_valid !== (k >= 2)) $display("FAIL stream_valid k=%0d got %b want %b", k, out_valid, k >= 2); else n_pass++;
            n_chk++; if (out_pc !== ((k >= 2) ? 32'(k - 2) : 32'd0)) $display("FAIL stream_pc k=%0d got %h", k, out_pc); else n_pass++;
            n_chk++; if (out_instr !== ((k >= 2) ? 32'(k - 2) + 32'h100 : 32'd0)) $display("FAIL stream_instr k=%0d got %h", k, out_instr); else n_pass++;
            n_chk++; if (occupancy !== ((k >= 2) ? 3'd1 : 3'd0)) $display("FAIL stream_occ k=%0d got %0d", k, occupancy); else n_pass++;
        end
    endtask

    task automatic test_stall_full();
        do_reset();
        fetch_en = 1'b1;
        @(negedge clk);
        @(negedge clk);
        stall_id = 1'b1;
        for (int k = 2; k < 9; k++) begin
            if (k > 2) @(negedge clk);
            #1;
            n_chk++; if (occupancy !== ((k >= 5) ? 3'd4 : 3'(k - 1))) $display("FAIL stall_occ k=%0d got %0d", k, occupancy); else n_pass++;
            n_chk++; if (imem_addr !== ((k >= 4) ? 32'd4 : 32'(k))) $display("FAIL stall_addr k=%0d got %h", k, imem_addr); else n_pass++;
            n_chk++; if (imem_req !== (k < 4)) $display("FAIL stall_req k=%0d got %b want %b", k, imem_req, k < 4); else n_pass++;
            n_chk++; if (out_pc !== 32'd0 || out_instr !== 32'h100) $display("FAIL stall_head k=%0d got %h/%h want 0/100", k, out_pc, out_instr); else n_pass++;
        end
        @(negedge clk);
        stall_id = 1'b0;
        for (int j = 0; j < 8; j++) begin
            if (j > 0) @(negedge clk);
            #1;
            n_chk++; if (out_valid !== 1'b1 || out_pc !== 32'(j)) $display("FAIL release_seq j=%0d got v=%b pc=%h want pc=%h", j, out_valid, out_pc, j); else n_pass++;
        end
    endtask

    task automatic test_redirect();
        do_reset();
        fetch_en = 1'b1;
        @(negedge clk);
        @(negedge clk);
        stall_id = 1'b1;
        @(negedge clk);
        @(negedge clk);
        #1;
        n_chk++; if (occupancy !== 3'd3) $display("FAIL redir_pre_occ got %0d want 3", occupancy); else n_pass++;
        redirect = 1'b1; redirect_pc = 32'h40;
        #1;
        n_chk++; if (out_valid !== 1'b0 || out_pc !== 32'd0) $display("FAIL redir_valid got %b/%h want 0/0", out_valid, out_pc); else n_pass++;
        n_chk++; if (imem_req !== 1'b0) $display("FAIL redir_req got %b want 0", imem_req); else n_pass++;
        @(negedge clk);
        redirect = 1'b0; stall_id = 1'b0;
        #1;
        n_chk++; if (occupancy !== 3'd0) $display("FAIL redir_occ got %0d want 0", occupancy); else n_pass++;
        n_chk++; if (out_valid !== 1'b0) $display("FAIL redir_post_valid got %b want 0", out_valid); else n_pass++;
        n_chk++; if (imem_addr !== 32'h40 || imem_req !== 1'b1) $display("FAIL redir_addr got %h/%b want 40/1", imem_addr, imem_req); else n_pass++;
`ifdef FETCH_PERF_EN
        n_chk++; if (perf_flushed !== 32'd4) $display("FAIL perf_flushed got %0d want 4", perf_flushed); else n_pass++;
`else
        n_chk++; if (perf_flushed !== 32'd0) $display("FAIL perf_flushed_tied got %0d want 0", perf_flushed); else n_pass++;
`endif
        @(negedge clk);
        #1;
        n_chk++; if (out_valid !== 1'b0 || imem_addr !== 32'h41) $display("FAIL redir_gap got %b/%h want 0/41", out_valid, imem_addr); else n_pass++;
        for (int j = 0; j < 4; j++) begin
            @(negedge clk);
            #1;
            n_chk++; if (out_valid !== 1'b1 || out_pc !== 32'h40 + 32'(j) || out_instr !== 32'h140 + 32'(j))
                $display("FAIL redir_seq j=%0d got v=%b %h/%h want %h", j, out_valid, out_pc, out_instr, 32'h40 + 32'(j)); else n_pass++;
        end
`ifdef FETCH_PERF_EN
        n_chk++; if (perf_fetched !== 32'd3) $display("FAIL perf_fetched got %0d want 3", perf_fetched); else n_pass++;
`else
        n_chk++; if (perf_fetched !== 32'd0) $display("FAIL perf_fetched_tied got %0d want 0", perf_fetched); else n_pass++;
`endif
    endtask

    task automatic test_redirect_stall();
        do_reset();
        fetch_en = 1'b1;
        repeat (4) @(negedge clk);
        #1;
        n_chk++; if (out_valid !== 1'b1 || out_pc !== 32'd2) $display("FAIL rs_head got %b/%h want 1/2", out_valid, out_pc); else n_pass++;
        redirect = 1'b1; stall_id = 1'b1; redirect_pc = 32'h80;
        #1;
        n_chk++; if (out_valid !== 1'b0) $display("FAIL rs_valid got %b want 0", out_valid); else n_pass++;
        @(negedge clk);
        redirect = 1'b0; stall_id = 1'b0;
        #1;
        n_chk++; if (occupancy !== 3'd0) $display("FAIL rs_occ got %0d want 0", occupancy); else n_pass++;
`ifdef FETCH_PERF_EN
        n_chk++; if (perf_fetched !== 32'd2 || perf_flushed !== 32'd2) $display("FAIL rs_perf got %0d/%0d want 2/2", perf_fetched, perf_flushed); else n_pass++;
`endif
        for (int j = 0; j < 5; j++) begin
            if (j > 0) @(negedge clk);
            #1;
            n_chk++; if (out_valid === 1'b1 && out_pc === 32'd2) $display("FAIL rs_stale j=%0d got pc %h want not 2", j, out_pc); else n_pass++;
            if (j >= 2) begin
                n_chk++; if (out_valid !== 1'b1 || out_pc !== 32'h80 + 32'(j - 2)) $display("FAIL rs_seq j=%0d got %b/%h", j, out_valid, out_pc); else n_pass++;
            end
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        fetch_en = 1'b1;
        @(negedge clk);
        @(negedge clk);
        stall_id = 1'b1;
        @(negedge clk);
        #1;
        n_chk++; if (occupancy !== 3'd2) $display("FAIL mid_pre_occ got %0d want 2", occupancy); else n_pass++;
        rst = 1'b1;
        #1;
        n_chk++; if (imem_req !== 1'b0) $display("FAIL mid_req got %b want 0", imem_req); else n_pass++;
        @(negedge clk);
        #1;
        n_chk++; if (occupancy !== 3'd0 || out_valid !== 1'b0 || imem_addr !== 32'd0)
            $display("FAIL mid_state got occ=%0d v=%b addr=%h want 0/0/0", occupancy, out_valid, imem_addr); else n_pass++;
        rst = 1'b0; stall_id = 1'b0;
        @(negedge clk);
        #1;
        n_chk++; if (occupancy !== 3'd0 || out_valid !== 1'b0) $display("FAIL mid_drop got occ=%0d v=%b want 0/0", occupancy, out_valid); else n_pass++;
        @(negedge clk);
        #1;
        n_chk++; if (out_valid !== 1'b1 || out_pc !== 32'd0 || out_instr !== 32'h100) $display("FAIL mid_restart got %b %h/%h", out_valid, out_pc, out_instr); else n_pass++;
    endtask

    task automatic test_wrap();
        logic [31:0] exp_pc [3];
        exp_pc[0] = 32'hFFFF_FFFF; exp_pc[1] = 32'd0; exp_pc[2] = 32'd1;
        do_reset();
        fetch_en = 1'b1; redirect = 1'b1; redirect_pc = 32'hFFFF_FFFF;
        @(negedge clk);
        redirect = 1'b0;
        #1;
        n_chk++; if (imem_addr !== 32'hFFFF_FFFF || imem_req !== 1'b1) $display("FAIL wrap_addr got %h/%b", imem_addr, imem_req); else n_pass++;
        @(negedge clk);
        #1;
        n_chk++; if (imem_addr !== 32'd0) $display("FAIL wrap_pc got %h want 0", imem_addr); else n_pass++;
        for (int j = 0; j < 3; j++) begin
            @(negedge clk);
            #1;
            n_chk++; if (out_valid !== 1'b1 || out_pc !== exp_pc[j] || out_instr !== exp_pc[j] + 32'h100)
                $display("FAIL wrap_seq j=%0d got %b %h/%h want %h", j, out_valid, out_pc, out_instr, exp_pc[j]); else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_stall_full();
        test_redirect();
        test_redirect_stall();
        test_reset_mid();
        test_wrap();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
